// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front
//               end: data width, instruction size, the queue entry type
//               {pc, instr} and the fixed word byte-mask.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [3:0] IMEM_MASK_WORD = 4'b1111;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch front-end control, instruction-memory
//               and decode-side signals.
//               master : the fetch unit (drives imem_* requests, dec_* head)
//               slave  : the surrounding core / memory / decode environment
// Ports       : stall, redirect, redirect_pc  - pipeline control
//               imem_request/we_re/mask/addr  - memory request
//               imem_valid/rdata              - memory response
//               dec_valid/instr/pc, dec_ready - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int XLEN = 32
);

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_request;
    logic            imem_we_re;
    logic [3:0]      imem_mask;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata;

    logic            dec_valid;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_ready;

    modport master (
        input  stall, redirect, redirect_pc, imem_valid, imem_rdata, dec_ready,
        output imem_request, imem_we_re, imem_mask, imem_addr,
               dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_valid, imem_rdata, dec_ready,
        input  imem_request, imem_we_re, imem_mask, imem_addr,
               dec_valid, dec_instr, dec_pc
    );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous show-ahead FIFO of fetch_entry_t. The head entry
//               is visible combinationally whenever count is non-zero.
//               flush empties the FIFO and takes priority over push/pop.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write one entry
//               pop             - consume the head entry (ignored if empty)
//               flush           - discard all entries
//               head            - current head entry
//               count           - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH   = 4,
    localparam int c_ptr_w = $clog2(DEPTH),
    localparam int c_cnt_w = c_ptr_w + 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               push,
    input  wire fetch_entry_t       push_data,
    input  wire logic               pop,
    input  wire logic               flush,
    output fetch_entry_t            head,
    output logic [c_cnt_w-1:0]      count
);

    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic w_pop;
    logic w_full;

    assign w_pop  = pop && (r_count != '0);
    assign w_full = (r_count == c_full);

    // Storage has no reset; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(push) - c_cnt_w'(w_pop);
        end
    end

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && w_full && !w_pop));
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end. Owns the PC, issues pipelined
//               in-order word reads to instruction memory under a credit
//               limit of DEPTH (queued + outstanding), buffers responses
//               tagged with their PC ahead of decode, and handles stall and
//               branch redirect (flush + discard of in-flight responses).
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - fetch_queue_if.master (control, imem, decode)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_queue_if.master bus
);

    localparam int                  c_cnt_w   = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0]    c_depth   = (c_cnt_w + 1)'(DEPTH);
    localparam logic [XLEN-1:0]     c_step    = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_resp_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;

    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w:0]   w_credit_used;
    logic               w_issue;
    logic               w_dropping;
    logic               w_push;
    logic               w_pop;
    logic               w_dec_valid;
    logic [c_cnt_w-1:0] w_outstanding_after_resp;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;

    // Credits cover both buffered entries and requests still in flight, so
    // every response is guaranteed a free slot when it arrives.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_issue       = !rst && !bus.stall && !bus.redirect && (w_credit_used < c_depth);

    assign w_dropping  = (r_drop != '0);
    assign w_push      = bus.imem_valid && !w_dropping && !bus.redirect;
    assign w_dec_valid = (w_count != '0);
    assign w_pop       = w_dec_valid && bus.dec_ready && !bus.redirect;

    // Outstanding count once this cycle's response (if any) is retired; on a
    // redirect every one of those is stale, including ones already being dropped.
    assign w_outstanding_after_resp = r_outstanding - c_cnt_w'(bus.imem_valid);

    assign w_push_data = '{pc: r_resp_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_after_resp + c_cnt_w'(w_issue);
            if (bus.redirect) begin
                r_pc      <= bus.redirect_pc;
                r_resp_pc <= bus.redirect_pc;
                r_drop    <= w_outstanding_after_resp;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + c_step;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_step;
                end
                if (bus.imem_valid && w_dropping) begin
                    r_drop <= r_drop - c_cnt_w'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (bus.redirect),
        .head      (w_head),
        .count     (w_count)
    );

    assign bus.imem_request = w_issue;
    assign bus.imem_we_re   = 1'b0;
    assign bus.imem_mask    = IMEM_MASK_WORD;
    assign bus.imem_addr    = r_pc;

    // Head fields read as zero while empty so stale storage never leaks out.
    assign bus.dec_valid = w_dec_valid;
    assign bus.dec_instr = w_dec_valid ? w_head.instr : '0;
    assign bus.dec_pc    = w_dec_valid ? w_head.pc    : '0;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A transaction-level
//               model (queue of expected decode entries, list of in-flight
//               requests with a stale flag, model PC) predicts the outputs
//               every cycle; a memory model answers requests in order with
//               variable latency. Directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { int due; logic [31:0] addr; } mem_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model state
    req_t        os[$];
    ent_t        mq[$];
    mem_t        sched[$];
    logic [31:0] m_pc;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;

    int n_checks;
    int n_err;

    // Per-step observations for directed checks
    bit          obs_req;
    logic [31:0] obs_addr;
    bit          obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    int          n_req_seen;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: present memory response, compare at negedge, advance model.
    task automatic step();
        bit          exp_req;
        bit          exp_valid;
        ent_t        h;
        req_t        r;
        int          due;
        if (!rst && sched.size() > 0 && sched[0].due == cyc) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = word_of(sched[0].addr);
            void'(sched.pop_front());
        end else begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
        end
        @(negedge clk);
        if (rst) begin
            chk("req_in_reset", 32'(bus.imem_request), 32'd0);
            os.delete();
            mq.delete();
            sched.delete();
            m_pc      = 32'h0;
            last_due  = cyc;
            obs_req   = 1'b0;
            obs_valid = 1'b0;
        end else begin
            exp_valid = (mq.size() > 0);
            exp_req   = !bus.stall && !bus.redirect && ((mq.size() + os.size()) < DEPTH);
            h         = exp_valid ? mq[0] : '{32'h0, 32'h0};
            chk("imem_request", 32'(bus.imem_request), 32'(exp_req));
            chk("imem_addr",    bus.imem_addr, m_pc);
            chk("imem_we_re",   32'(bus.imem_we_re), 32'd0);
            chk("imem_mask",    32'(bus.imem_mask), 32'hF);
            chk("dec_valid",    32'(bus.dec_valid), 32'(exp_valid));
            chk("dec_pc",       bus.dec_pc, h.pc);
            chk("dec_instr",    bus.dec_instr, h.instr);
            obs_req   = bus.imem_request;
            obs_addr  = bus.imem_addr;
            obs_valid = bus.dec_valid;
            obs_pc    = bus.dec_pc;
            obs_instr = bus.dec_instr;
            // Memory side answers whatever the DUT actually requested.
            if (bus.imem_request) begin
                n_req_seen++;
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                sched.push_back('{due, bus.imem_addr});
            end
            // Model: pop, then response, then redirect, then issue.
            if (exp_valid && bus.dec_ready && !bus.redirect) void'(mq.pop_front());
            if (bus.imem_valid && os.size() > 0) begin
                r = os.pop_front();
                if (!r.stale && !bus.redirect) mq.push_back('{r.addr, word_of(r.addr)});
            end
            if (bus.redirect) begin
                mq.delete();
                foreach (os[k]) os[k].stale = 1'b1;
                m_pc = bus.redirect_pc;
            end else if (exp_req) begin
                os.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect    = 1'b0;
    endtask

    // Steps until the head is valid (bounded) and checks its pc/instr.
    task automatic expect_first(input string name, input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (obs_valid) found = 1'b1;
        end
        chk({name, "_found"}, 32'(found), 32'd1);
        chk({name, "_pc"},    obs_pc, pc);
        chk({name, "_instr"}, obs_instr, word_of(pc));
    endtask

    initial begin
        int  base;
        bit  bad;
        n_checks = 0; n_err = 0; cyc = 0; last_due = 0; n_req_seen = 0;
        lat_min = 1; lat_max = 1;
        m_pc = 32'h0;
        rst = 1'b1;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.dec_ready = 1'b1; bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0;
        repeat (3) step();
        rst = 1'b0;

        // Reset release, 1-cycle memory: request at 0, dec_valid from 2.
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                chk("t0_req",  32'(obs_req), 32'd1);
                chk("t0_addr", obs_addr, 32'h0);
            end else if (i == 1) begin
                chk("t1_dec_valid", 32'(obs_valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(obs_valid), 32'd1);
                chk("stream_pc",    obs_pc, 32'((i - 2) * 4));
            end
        end

        // Back-pressure: exactly DEPTH requests, then one per released entry.
        bus.dec_ready = 1'b0;
        do_redirect(32'h400);
        base = n_req_seen;
        repeat (12) step();
        chk("bp_requests", 32'(n_req_seen - base), 32'd4);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        base = n_req_seen;
        repeat (6) step();
        chk("bp_release_one", 32'(n_req_seen - base), 32'd1);
        bus.dec_ready = 1'b1;

        // Redirect with requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        repeat (10) step();
        do_redirect(32'h100);
        expect_first("redir100", 32'h100);

        // Redirect coinciding with a response and a pop on 1-cycle memory.
        lat_min = 1; lat_max = 1;
        repeat (8) step();
        do_redirect(32'h180);
        step(); chk("redir_r1_empty", 32'(obs_valid), 32'd0);
        step(); chk("redir_r2_empty", 32'(obs_valid), 32'd0);
        step(); chk("redir_r3_valid", 32'(obs_valid), 32'd1);
        chk("redir_r3_pc", obs_pc, 32'h180);

        // Stall: no issue for 5 cycles, resumes right after.
        repeat (4) step();
        bus.stall = 1'b1;
        base = n_req_seen;
        repeat (5) step();
        chk("stall_no_req", 32'(n_req_seen - base), 32'd0);
        bus.stall = 1'b0;
        step();
        chk("stall_resume", 32'(obs_req), 32'd1);

        // Back-to-back redirects: only the 0x300 path reaches decode.
        lat_min = 3; lat_max = 3;
        repeat (8) step();
        do_redirect(32'h200);
        do_redirect(32'h300);
        expect_first("b2b", 32'h300);
        bad = 1'b0;
        repeat (30) begin
            step();
            if (obs_valid && obs_pc < 32'h300) bad = 1'b1;
        end
        chk("b2b_no_old_path", 32'(bad), 32'd0);

        // Randomized traffic with one mid-run reset.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                bus.redirect = 1'b0;
                bus.stall    = 1'b0;
                rst = 1'b1;
                repeat (2) step();
                rst = 1'b0;
            end
            bus.stall       = ($urandom_range(0, 9) < 2);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
            bus.dec_ready   = ($urandom_range(0, 9) < 7);
            step();
        end
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        bus.dec_ready = 1'b1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: owns the PC and issues pipelined, in-order word reads to instruction memory. It buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue ahead of decode. It supports a decode back-pressure handshake, a load stall and a branch redirect that flushes the queue and discards in-flight responses. It sits between the instruction memory port and the decode stage.

## Interface

- XLEN, 32, address/data width; only 32 supported this generation
- DEPTH, 4, queue entries and max outstanding requests; power of 2, ≥ 2
- RESET_PC, 32'h0000_0000, PC after reset

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  load in progress without dmem valid; suppresses new requests
- redirect  in  1  branch/jump resolved taken; flush and restart
- redirect_pc  in  XLEN  new fetch address, word aligned
- imem_request  out  1  read request this cycle
- imem_we_re  out  1  constant 0 (read)
- imem_mask  out  4  constant 4'b1111
- imem_addr  out  XLEN  request address (= pc)
- imem_valid  in  1  response valid; responses in request order, ≥1 cycle latency
- imem_rdata  in  XLEN  response instruction
- dec_valid  out  1  queue head valid
- dec_instr  out  XLEN  head instruction
- dec_pc  out  XLEN  head PC
- dec_ready  in  1  decode accepts head

## Operation

- State: pc, resp_pc, queue count, outstanding count, drop count; counters are $clog2(DEPTH)+1 bits.
- Issue: imem_request = !rst && !stall && !redirect && (count + outstanding < DEPTH). Every asserted cycle is one accepted request. On issue, pc += 4 and outstanding++.
- Response with drop > 0: the word is discarded, drop--, outstanding--.
- Response otherwise: push {resp_pc, imem_rdata}, resp_pc += 4, outstanding--.
- Pop: dec_valid && dec_ready. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by the credit rule. A push into a full queue is an assertion failure.
- Redirect:
  - pc ← redirect_pc and resp_pc ← redirect_pc.
  - Queue is flushed: count ← 0. A pop in the same cycle is ignored.
  - drop ← outstanding after this cycle's response is accounted; a response arriving in the redirect cycle is itself discarded.
  - No request in the redirect cycle.
- Redirect while drop > 0 accumulates correctly: drop always equals the number of stale responses still in flight.
- Stall only blocks issue. Responses and pops continue.
- All adds wrap modulo 2^XLEN. No misalignment check.
- Reset values: pc = resp_pc = RESET_PC; count = outstanding = drop = 0; imem_request = 0; dec_valid = 0; dec_instr = dec_pc = 0 while empty.
- Reset mid-operation: all state cleared. Later responses to pre-reset requests are a memory-side error (memory is reset together with this block).

## Timing

- Queue write is registered. A response in cycle N makes dec_valid visible in N+1.
- 1-cycle memory, first cycle after reset release = 0: request at 0, response at 1, dec_valid at 2 with dec_pc = RESET_PC.
- Redirect in cycle R: first new-path request at R+1; dec_valid for redirect_pc no earlier than R+3.
- Sustained throughput is one instruction per cycle with 1-cycle memory and dec_ready high.
- Outputs depend combinationally only on stall, redirect and registered state. There is no imem_valid → imem_request path.

## Structure

- Package fetch_pkg: XLEN default, INSTR_BYTES = 4, the fetch_entry_t struct {pc, instr}, and the IMEM_MASK_WORD = 4'b1111 constant.
- Sub-module fetch_fifo: sync FIFO of fetch_entry_t with params DEPTH, ports push/pop/flush/count, show-ahead head. It is reusable by later decode buffers.
- Top level holds the pc/resp_pc registers, counters, issue logic and drop logic.

## Test plan

- Reset with 1-cycle memory and dec_ready = 1: dec_pc sequence 0x0, 0x4, 0x8… from cycle 2, one per cycle; imem_mask = 4'hF and imem_we_re = 0 throughout.
- dec_ready = 0 with DEPTH = 4: exactly 4 requests issued, count = 4, then imem_request held 0. A single dec_ready pulse releases exactly one new request.
- Redirect to 0x100 with 3 requests outstanding and 3-cycle memory latency: 3 stale responses dropped; the next dec_pc is 0x100 with the word returned for 0x100.
- Redirect in the same cycle as imem_valid and dec_ready: that response is dropped, the queue is empty the next cycle, and there is no spurious dec_valid.
- stall high for 5 cycles: no requests; already-queued entries still drain; issue resumes the cycle after stall falls.
- Back-to-back redirects (0x200 then 0x300) with outstanding requests: only instructions from 0x300 onward ever reach decode.
